// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 encodings, LSU states, strobe bases and access-legality helpers
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} lsu_state_e;
  function automatic logic f3_ok(input logic ld, input logic [2:0] f3);
    return ld ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (f3 inside {F3_B, F3_H, F3_W});
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ack data-memory port
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a read word and extends it
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = addr_i[1] ? (addr_i[0] ? mem_rdata_i[31:24] : mem_rdata_i[23:16])
                  : (addr_i[0] ? mem_rdata_i[15:8]  : mem_rdata_i[7:0]);
    h = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    data_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
             funct3_i == F3_H  ? {{16{h[15]}}, h} :
             funct3_i == F3_BU ? {24'd0, b} :
             funct3_i == F3_HU ? {16'd0, h} : mem_rdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a req/ack memory port
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] readData,
  load_store_unit_if.master mem
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d, mwdata_q, mwdata_d, ld_data, rep;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  strb_q, strb_d, strb;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_q, ld_d, req_q, req_d, we_q, we_d, fault_q, fault_d, bad;
  lsu_load_align u_align (
    .mem_rdata_i(mem.mem_rdata),
    .addr_i     (addr_q[1:0]),
    .funct3_i   (f3_q),
    .data_o     (ld_data)
  );
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;
  assign fault         = fault_q;
  assign readData      = rdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;
  assign mem.mem_wstrb = strb_q;
  always_comb begin
    bad  = !f3_ok(ld_q, f3_q) || misaligned(f3_q, addr_q[1:0]);
    rep  = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    strb = f3_q[1:0] == 2'b00 ? STRB_B << addr_q[1:0] : f3_q[1:0] == 2'b01 ? STRB_H << addr_q[1:0] : STRB_W;
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    ld_d     = ld_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    strb_d   = strb_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = (memRead ^ memWrite) ? S_CHECK : S_DONE;
        fault_d = ~(memRead ^ memWrite);
        addr_d  = address;
        wdata_d = writeData;
        f3_d    = funct3;
        ld_d    = memRead;
      end
      S_CHECK: begin
        state_d  = bad ? S_DONE : S_REQ;
        fault_d  = bad;
        req_d    = ~bad;
        we_d     = ~ld_q;
        maddr_d  = {addr_q[31:2], 2'b00};
        mwdata_d = rep;
        strb_d   = ld_q ? 4'b0000 : strb;
        cnt_d    = '0;
      end
      S_REQ: begin
        // an ack on the timeout edge still wins
        if (mem.mem_ack || cnt_q == TO_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          fault_d = ~mem.mem_ack;
        end else cnt_d = cnt_q + 8'd1;
        if (mem.mem_ack && ld_q) rdata_d = ld_data;
      end
      default: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      ld_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      strb_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      ld_q     <= ld_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      strb_q   <= strb_d;
      fault_q  <= fault_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses checked every cycle against a timeline model
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clock = 1'b0;
  logic        reset, start, memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] address, writeData;
  logic        busy, done, fault;
  logic [31:0] readData;
  load_store_unit_if bus();
  load_store_unit #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .address(address), .writeData(writeData), .busy(busy), .done(done),
    .fault(fault), .readData(readData), .mem(bus)
  );
  int nvec = 0, nmis = 0;
  logic        chk = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_fault = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_rd = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_strb = '0;
  logic [31:0] o_addr = '0, o_wdata = '0;
  logic [3:0]  o_strb = '0;
  logic        o_we = 1'b0;
  always #5 clock = ~clock;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock) if (chk) begin
    cmp("busy", 32'(busy), 32'(e_busy));
    cmp("done", 32'(done), 32'(e_done));
    if (e_done) cmp("fault", 32'(fault), 32'(e_fault));
    cmp("readData", readData, e_rd);
    cmp("mem_req", 32'(bus.mem_req), 32'(e_req));
    if (e_req) begin
      cmp("mem_we", 32'(bus.mem_we), 32'(e_we));
      cmp("mem_addr", bus.mem_addr, e_addr);
      cmp("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
      if (e_we) cmp("mem_wdata", bus.mem_wdata, e_wdata);
    end
  end
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int lane;
    logic [31:0] b, h;
    lane = int'(a[1:0]);
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 32'd128 ? b - 32'd256 : b;
      3'd1: return h >= 32'd32768 ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rdat, input bit poke);
    bit ld, legal, go, ok;
    int size, lane;
    ld    = rd & ~wr;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << int'(f3[1:0]);
    lane  = int'(a[1:0]);
    go    = (rd ^ wr) && legal && (int'(a[3:0]) % size == 0);
    ok    = 1'b0;
    start = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; address = a; writeData = wd;
    cyc();
    start = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    e_busy = 1'b1;
    if (rd ^ wr) begin
      if (poke) begin start = 1'b1; memRead = 1'b1; end
      cyc();
      start = 1'b0; memRead = 1'b0;
      if (go) begin
        e_req   = 1'b1;
        e_we    = ~ld;
        e_addr  = a & 32'hFFFFFFFC;
        e_strb  = ld ? 4'h0 : f3 == 3'd0 ? 4'(1 << lane) : f3 == 3'd1 ? 4'(3 << lane) : 4'hF;
        e_wdata = f3 == 3'd0 ? (wd & 32'hFF) * 32'h01010101 : f3 == 3'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        for (int k = 1; k <= TO; k++) begin
          o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_strb = bus.mem_wstrb; o_we = bus.mem_we;
          if (k == ack_at) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdat; end
          cyc();
          bus.mem_ack = 1'b0; bus.mem_rdata = '0;
          if (k == ack_at) begin ok = 1'b1; break; end
        end
        e_req = 1'b0;
        if (ok && ld) e_rd = load_val(f3, a, rdat);
      end
    end
    e_done = 1'b1; e_fault = ~ok;
    cyc();
    e_done = 1'b0; e_busy = 1'b0; e_fault = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0; address = '0; writeData = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    cyc();
    chk = 1'b1;
    cyc();
    reset = 1'b0;
    cmp("reset_readData", readData, 32'h0);
    cmp("reset_busy", 32'(busy), 32'h0);
    access(0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 2, 32'h0, 0);
    cmp("sw_addr", o_addr, 32'h104);
    cmp("sw_strb", 32'(o_strb), 32'hF);
    cmp("sw_wdata", o_wdata, 32'hDEADBEEF);
    cmp("sw_we", 32'(o_we), 32'h1);
    access(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF1234, 0);
    cmp("lb_data", readData, 32'hFFFFFF80);
    access(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF1234, 0);
    cmp("lbu_data", readData, 32'h00000080);
    access(0, 1, 3'd1, 32'h102, 32'h0000ABCD, 1, 32'h0, 1);
    cmp("sh_strb", 32'(o_strb), 32'hC);
    cmp("sh_wdata", o_wdata, 32'hABCDABCD);
    cmp("sh_addr", o_addr, 32'h100);
    access(1, 0, 3'd2, 32'h100, 32'h0, 3, 32'h11111111, 0);
    cmp("lw_data", readData, 32'h11111111);
    access(1, 0, 3'd2, 32'h102, 32'h0, 1, 32'h0, 0);
    cmp("lw_mis_keep", readData, 32'h11111111);
    access(1, 0, 3'd2, 32'h200, 32'h0, 0, 32'h0, 0);
    cmp("timeout_keep", readData, 32'h11111111);
    cyc();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
    cyc();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    cyc();
    cmp("late_ack_keep", readData, 32'h11111111);
    access(1, 0, 3'd1, 32'h106, 32'h0, 1, 32'h80017FFF, 0);
    cmp("lh_data", readData, 32'hFFFF8001);
    access(1, 0, 3'd5, 32'h104, 32'h0, 1, 32'h1234F00D, 0);
    cmp("lhu_data", readData, 32'h0000F00D);
    access(1, 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 0);
    access(0, 1, 3'd4, 32'h100, 32'h1, 1, 32'h0, 0);
    access(1, 1, 3'd2, 32'h100, 32'h1, 1, 32'h0, 0);
    access(0, 0, 3'd2, 32'h100, 32'h1, 1, 32'h0, 0);
    access(0, 1, 3'd1, 32'h103, 32'h1, 1, 32'h0, 0);
    access(0, 1, 3'd0, 32'h101, 32'h000000A5, 1, 32'h0, 0);
    cmp("sb_strb", 32'(o_strb), 32'h2);
    cmp("sb_wdata", o_wdata, 32'hA5A5A5A5);
    access(1, 0, 3'd2, 32'h300, 32'h0, TO, 32'hCAFEF00D, 0);
    cmp("ack_at_timeout", readData, 32'hCAFEF00D);
    start = 1'b1; memWrite = 1'b1; funct3 = 3'd2; address = 32'h40; writeData = 32'h12345678;
    cyc();
    start = 1'b0; memWrite = 1'b0; e_busy = 1'b1;
    cyc();
    e_req = 1'b1; e_we = 1'b1; e_addr = 32'h40; e_strb = 4'hF; e_wdata = 32'h12345678;
    reset = 1'b1;
    cyc();
    reset = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_rd = '0;
    cmp("rst_mid_readData", readData, 32'h0);
    cmp("rst_mid_req", 32'(bus.mem_req), 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    cyc();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    cyc();
    cmp("rst_mid_idle", 32'(busy), 32'h0);
    access(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0BADCAFE, 0);
    cmp("post_rst_lw", readData, 32'h0BADCAFE);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
